// File: rtl/rr_client_4z.sv
// Four-channel command queue client for a round-robin arbiter: per-channel FIFOs feed
// a single downstream port, one granted transfer at a time.
module rr_client_4z #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic [3:0]      requests,
    input  logic [3:0]      grants,
    output logic            accepted,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_chan,
    input  logic            out_ready,
    output logic            err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, ACK, WAIT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    chan_q, chan_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q [4];
    logic [CW-1:0] count_d [4];
    logic [AW-1:0] wptr_q  [4];
    logic [AW-1:0] wptr_d  [4];
    logic [AW-1:0] rptr_q  [4];
    logic [AW-1:0] rptr_d  [4];
    logic [DW-1:0] mem_q   [4][DEPTH];

    logic [3:0]    push;
    logic [3:0]    pop;
    logic [1:0]    gidx;

    // A full queue refuses the push even when it is popped in the same cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            push[i] = in_valid[i] && (count_q[i] != FULL);
        end
        pop = (state_q == SEND && out_ready) ? (4'b0001 << chan_q) : 4'b0000;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            count_d[i] = count_q[i];
            wptr_d[i]  = wptr_q[i];
            rptr_d[i]  = rptr_q[i];
            if (push[i]) begin
                wptr_d[i] = wptr_q[i] + AW'(1);
            end
            if (pop[i]) begin
                rptr_d[i] = rptr_q[i] + AW'(1);
            end
            if (push[i] && !pop[i]) begin
                count_d[i] = count_q[i] + CW'(1);
            end else if (pop[i] && !push[i]) begin
                count_d[i] = count_q[i] - CW'(1);
            end
        end
    end

    always_comb begin
        gidx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grants[i]) begin
                gidx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (grants != 4'b0000) begin
                    if ($onehot(grants) && count_q[gidx] != '0) begin
                        state_d = SEND;
                        chan_d  = gidx;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = WAIT;
            end
            WAIT: begin
                // The arbiter keeps the grant one cycle past accepted; wait for it to drop.
                if (grants == 4'b0000) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            chan_q  <= 2'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= '0;
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= count_d[i];
                wptr_q[i]  <= wptr_d[i];
                rptr_q[i]  <= rptr_d[i];
            end
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= in_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_ready[i] = rst || (count_q[i] != FULL);
            requests[i] = !rst && (count_q[i] != '0);
        end
        out_valid = !rst && (state_q == SEND);
        accepted  = !rst && (state_q == ACK);
        out_data  = out_valid ? mem_q[chan_q][rptr_q[chan_q]] : '0;
        out_chan  = rst ? 2'd0 : chan_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_rr_client_4z.sv
// Randomized bench for rr_client_4z: per-channel queues modelled as SV queues,
// transfers driven with an explicit expected cycle timeline.
module tb_rr_client_4z;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      in_valid = 4'b0;
    logic [4*DW-1:0] in_data = '0;
    logic [3:0]      in_ready;
    logic [3:0]      requests;
    logic [3:0]      grants = 4'b0;
    logic            accepted;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_chan;
    logic            out_ready = 1'b0;
    logic            err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] mq [4][$];
    logic          m_err = 1'b0;

    rr_client_4z #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .requests(requests), .grants(grants), .accepted(accepted),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the queue model at the edge, check queue flags after it.
    task automatic cyc(input logic [3:0] iv, input logic [4*DW-1:0] id, input logic [3:0] g,
                       input logic r, input logic [3:0] popm, input logic rs);
        logic [3:0] exp_req;
        logic [3:0] exp_rdy;
        in_valid  = iv;
        in_data   = id;
        grants    = g;
        out_ready = r;
        rst       = rs;
        @(posedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            if (rs) begin
                mq[ch].delete();
            end else begin
                bit full;
                full = (mq[ch].size() == DEPTH);
                if (popm[ch] && mq[ch].size() > 0) void'(mq[ch].pop_front());
                if (iv[ch] && !full) mq[ch].push_back(id[ch*DW +: DW]);
            end
        end
        if (rs) m_err = 1'b0;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            exp_req[ch] = !rs && (mq[ch].size() != 0);
            exp_rdy[ch] = rs || (mq[ch].size() != DEPTH);
        end
        n_cmp++;
        if (requests !== exp_req || in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL queue_flags t=%0t requests=%b in_ready=%b required requests=%b in_ready=%b",
                     $time, requests, in_ready, exp_req, exp_rdy);
        end
        n_cmp++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL err_flag t=%0t err=%b required %b", $time, err, m_err);
        end
    endtask

    // Full grant/handshake/accept/release sequence on channel ch.
    task automatic do_xfer(input int ch, input int nwait, input int hold, input bit rp);
        logic [DW-1:0] w;
        logic [3:0]    g;
        logic [1:0]    c2;
        g  = 4'b0001 << ch;
        c2 = ch[1:0];
        w  = mq[ch][0];
        cyc(rp ? 4'($urandom) : 4'b0, $urandom, g, 1'b0, 4'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== w || out_chan !== c2 || accepted !== 1'b0) begin
            n_fail++;
            $display("FAIL send_start ch=%0d valid=%b data=%h chan=%0d acc=%b required 1 %h %0d 0",
                     ch, out_valid, out_data, out_chan, accepted, w, c2);
        end
        repeat (nwait) begin
            cyc(rp ? 4'($urandom) : 4'b0, $urandom, rp ? 4'($urandom) : g, 1'b0, 4'b0, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== w || out_chan !== c2 || accepted !== 1'b0) begin
                n_fail++;
                $display("FAIL send_stall ch=%0d valid=%b data=%h chan=%0d acc=%b required 1 %h %0d 0",
                         ch, out_valid, out_data, out_chan, accepted, w, c2);
            end
        end
        cyc(rp ? 4'($urandom) : 4'b0, $urandom, g, 1'b1, g, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || accepted !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_pulse ch=%0d valid=%b acc=%b required 0 1", ch, out_valid, accepted);
        end
        for (int k = 0; k <= hold; k++) begin
            cyc(rp ? 4'($urandom) : 4'b0, $urandom, g, 1'b1, 4'b0, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b0 || accepted !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold ch=%0d k=%0d valid=%b acc=%b required 0 0",
                         ch, k, out_valid, accepted);
            end
        end
        cyc(rp ? 4'($urandom) : 4'b0, $urandom, 4'b0, 1'b1, 4'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || accepted !== 1'b0) begin
            n_fail++;
            $display("FAIL release ch=%0d valid=%b acc=%b required 0 0", ch, out_valid, accepted);
        end
    endtask

    task automatic test_reset();
        cyc(4'b0, '0, 4'b0, 1'b0, 4'b0, 1'b1);
        cyc(4'b1111, 32'h11223344, 4'b0001, 1'b1, 4'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || accepted !== 1'b0 || out_data !== '0 || out_chan !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs valid=%b acc=%b data=%h chan=%0d required 0 0 00 0",
                     out_valid, accepted, out_data, out_chan);
        end
        cyc(4'b0, '0, 4'b0, 1'b0, 4'b0, 1'b0);
    endtask

    task automatic test_single();
        cyc(4'b0100, 32'h00A5_0000, 4'b0, 1'b0, 4'b0, 1'b0);
        n_cmp++;
        if (mq[2].size() != 1 || mq[2][0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_model size=%0d required 1", mq[2].size());
        end
        do_xfer(2, 0, 0, 1'b0);
    endtask

    task automatic test_fill();
        logic [DW-1:0] words [4];
        words[0] = 8'h10; words[1] = 8'h21; words[2] = 8'h32; words[3] = 8'h43;
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0001, {24'h0, words[k]}, 4'b0, 1'b0, 4'b0, 1'b0);
        end
        n_cmp++;
        if (in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full in_ready0=%b required 0", in_ready[0]);
        end
        cyc(4'b0001, 32'h0000_00EE, 4'b0, 1'b0, 4'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (mq[0][0] !== words[k]) begin
                n_fail++;
                $display("FAIL fill_order k=%0d head=%h required %h", k, mq[0][0], words[k]);
            end
            do_xfer(0, k % 2, 0, 1'b0);
        end
        n_cmp++;
        if (requests[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_drained requests0=%b required 0", requests[0]);
        end
    endtask

    task automatic test_backpressure();
        cyc(4'b1000, 32'h3C00_0000, 4'b0, 1'b0, 4'b0, 1'b0);
        do_xfer(3, 5, 0, 1'b0);
    endtask

    task automatic test_err();
        cyc(4'b0011, 32'h0000_7766, 4'b0, 1'b0, 4'b0, 1'b0);
        m_err = 1'b1;
        cyc(4'b0, '0, 4'b0011, 1'b1, 4'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0, '0, (k == 0) ? 4'b0011 : 4'b1000, 1'b1, 4'b0, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b0 || accepted !== 1'b0) begin
                n_fail++;
                $display("FAIL err_grant k=%0d valid=%b acc=%b required 0 0", k, out_valid, accepted);
            end
        end
        cyc(4'b0, '0, 4'b0, 1'b1, 4'b0, 1'b0);
        do_xfer(1, 1, 0, 1'b0);
        cyc(4'b0, '0, 4'b0, 1'b0, 4'b0, 1'b1);
        cyc(4'b0, '0, 4'b0, 1'b0, 4'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        cyc(4'b0010, 32'h0000_5100, 4'b0, 1'b0, 4'b0, 1'b0);
        cyc(4'b0010, 32'h0000_5200, 4'b0, 1'b0, 4'b0, 1'b0);
        do_xfer(1, 0, 3, 1'b0);
        n_cmp++;
        if (mq[1].size() != 1 || requests[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_no_second size=%0d requests1=%b required 1 1", mq[1].size(), requests[1]);
        end
        do_xfer(1, 0, 0, 1'b0);
    endtask

    task automatic test_rst_mid();
        cyc(4'b0010, 32'h0000_9900, 4'b0, 1'b0, 4'b0, 1'b0);
        cyc(4'b0, '0, 4'b0010, 1'b0, 4'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_send valid=%b required 1", out_valid);
        end
        cyc(4'b0, '0, 4'b0010, 1'b1, 4'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || accepted !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_abort valid=%b acc=%b required 0 0", out_valid, accepted);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0, '0, 4'b0, 1'b1, 4'b0, 1'b0);
            n_cmp++;
            if (accepted !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_after k=%0d valid=%b acc=%b required 0 0", k, out_valid, accepted);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int start;
            int pick;
            repeat ($urandom_range(0, 3)) cyc(4'($urandom), $urandom, 4'b0, 1'b0, 4'b0, 1'b0);
            start = $urandom_range(0, 3);
            pick  = -1;
            for (int k = 0; k < 4; k++) begin
                if (pick < 0 && mq[(start + k) % 4].size() != 0) pick = (start + k) % 4;
            end
            if (pick >= 0) do_xfer(pick, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_err();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
